// File: rtl/alt_merge_if.sv
// rtl/alt_merge_if.sv - pulse-channel and status bundle for alt_merge
interface alt_merge_if #(
   parameter int CNT_W = 8
);
   logic [1:0]       y_in;
   logic             clr_err;
   logic             x_out;
   logic             phase;
   logic             busy;
   logic             err;
   logic [CNT_W-1:0] pair_cnt;

   modport master (
      output y_in, clr_err,
      input  x_out, phase, busy, err, pair_cnt
   );

   modport slave (
      input  y_in, clr_err,
      output x_out, phase, busy, err, pair_cnt
   );
endinterface

// File: rtl/alt_merge.sv
// rtl/alt_merge.sv - alternating A/B pulse merger with order checking
module alt_merge #(
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_W     = 4,
   parameter int CNT_W       = 8
) (
   input  logic      clk,
   input  logic      rst,
   alt_merge_if.slave bus
);

   typedef enum logic [1:0] {WAIT_A, OUT_A, WAIT_B, OUT_B} state_t;

   localparam logic [3:0] PULSE_LD = 4'(PULSE_W);

   logic [SYNC_STAGES-1:0] sync_a_q, sync_a_d;
   logic [SYNC_STAGES-1:0] sync_b_q, sync_b_d;
   logic [1:0]             prev_q, prev_d;
   logic                   edge_a, edge_b;

   state_t                 state_q, state_d;
   logic [3:0]             timer_q, timer_d;
   logic                   x_out_q, x_out_d;
   logic                   phase_q, phase_d;
   logic                   busy_q, busy_d;
   logic                   err_q, err_d;
   logic                   err_set;
   logic [CNT_W-1:0]       pair_cnt_q, pair_cnt_d;

   // Synchronizers are never reset, so a level held across reset is not seen as an edge.
   always_comb begin
      sync_a_d = {sync_a_q[SYNC_STAGES-2:0], bus.y_in[1]};
      sync_b_d = {sync_b_q[SYNC_STAGES-2:0], bus.y_in[0]};
      prev_d   = {sync_a_q[SYNC_STAGES-1], sync_b_q[SYNC_STAGES-1]};
      edge_a   = sync_a_q[SYNC_STAGES-1] & ~prev_q[1];
      edge_b   = sync_b_q[SYNC_STAGES-1] & ~prev_q[0];
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      x_out_d    = x_out_q;
      pair_cnt_d = pair_cnt_q;
      err_set    = 1'b0;
      case (state_q)
         WAIT_A: begin
            if (edge_a) begin
               state_d = OUT_A;
               x_out_d = 1'b1;
               timer_d = PULSE_LD;
            end
            if (edge_b) err_set = 1'b1;
         end
         WAIT_B: begin
            if (edge_b) begin
               state_d = OUT_B;
               x_out_d = 1'b1;
               timer_d = PULSE_LD;
            end
            if (edge_a) err_set = 1'b1;
         end
         OUT_A, OUT_B: begin
            if (edge_a || edge_b) err_set = 1'b1;
            if (timer_q <= 4'd1) begin
               x_out_d = 1'b0;
               timer_d = 4'd0;
               if (state_q == OUT_A) begin
                  state_d = WAIT_B;
               end else begin
                  state_d    = WAIT_A;
                  pair_cnt_d = pair_cnt_q + CNT_W'(1);
               end
            end else begin
               timer_d = timer_q - 4'd1;
            end
         end
         default: state_d = WAIT_A;
      endcase
      // A fresh error in the clearing cycle keeps the flag set.
      err_d   = err_set | (err_q & ~bus.clr_err);
      phase_d = (state_d == WAIT_B) || (state_d == OUT_B);
      busy_d  = (state_d == OUT_A) || (state_d == OUT_B);
   end

   always_ff @(posedge clk) begin
      sync_a_q <= sync_a_d;
      sync_b_q <= sync_b_d;
      prev_q   <= prev_d;
      if (rst) begin
         state_q    <= WAIT_A;
         timer_q    <= 4'd0;
         x_out_q    <= 1'b0;
         phase_q    <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
         pair_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         x_out_q    <= x_out_d;
         phase_q    <= phase_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
         pair_cnt_q <= pair_cnt_d;
      end
   end

   assign bus.x_out    = x_out_q;
   assign bus.phase    = phase_q;
   assign bus.busy     = busy_q;
   assign bus.err      = err_q;
   assign bus.pair_cnt = pair_cnt_q;

endmodule

// File: tb/tb_alt_merge.sv
// tb/tb_alt_merge.sv - scoreboard bench for alt_merge
module tb_alt_merge;

   localparam int SYNC = 2;
   localparam int PW   = 4;

   typedef struct {
      int start;
      int width;
   } sb_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   sb_t  sb[$];
   sb_t  e;
   logic x_prev = 1'b0;
   int   run = 0;
   int   cur_w = 0;

   alt_merge_if #(.CNT_W(8)) bus0 ();
   alt_merge_if #(.CNT_W(2)) bus1 ();

   alt_merge #(.SYNC_STAGES(SYNC), .PULSE_W(PW), .CNT_W(8)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0)
   );
   alt_merge #(.SYNC_STAGES(SYNC), .PULSE_W(PW), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse(input int ch, input int w, input bit acc, input int expw);
      if (acc) sb.push_back('{cyc + 1 + SYNC, expw});
      bus0.y_in[ch] = 1'b1;
      bus1.y_in[ch] = 1'b1;
      tick(w);
      bus0.y_in[ch] = 1'b0;
      bus1.y_in[ch] = 1'b0;
   endtask

   task automatic clear_err();
      bus0.clr_err = 1'b1;
      bus1.clr_err = 1'b1;
      tick(1);
      bus0.clr_err = 1'b0;
      bus1.clr_err = 1'b0;
   endtask

   // Every rising x_out must match the oldest expected pulse in start cycle and width.
   always @(negedge clk) begin
      if (bus0.x_out && !x_prev) begin
         if (sb.size() == 0) begin
            check("x_unexpected", cyc, -1);
            cur_w = -1;
         end else begin
            e = sb.pop_front();
            check("x_start", cyc, e.start);
            check("busy_hi", int'(bus0.busy), 1);
            cur_w = e.width;
         end
         run = 0;
      end
      if (bus0.x_out) run++;
      else if (x_prev) check("x_width", run, cur_w);
      x_prev = bus0.x_out;
   end

   initial begin
      bus0.y_in = 2'b00;  bus1.y_in = 2'b00;
      bus0.clr_err = 1'b0; bus1.clr_err = 1'b0;
      rst = 1'b1;
      tick(4);
      check("rst_x", int'(bus0.x_out), 0);
      check("rst_phase", int'(bus0.phase), 0);
      check("rst_busy", int'(bus0.busy), 0);
      check("rst_err", int'(bus0.err), 0);
      check("rst_cnt", int'(bus0.pair_cnt), 0);
      rst = 1'b0;
      tick(2);

      // basic A then B pair
      pulse(1, 3, 1, PW);
      tick(17);
      check("t1_phase_b", int'(bus0.phase), 1);
      pulse(0, 3, 1, PW);
      tick(17);
      check("t1_phase_a", int'(bus0.phase), 0);
      check("t1_cnt", int'(bus0.pair_cnt), 1);
      check("t1_err", int'(bus0.err), 0);

      // B first is rejected, then cleared, then A accepted
      pulse(0, 3, 0, 0);
      tick(10);
      check("t2_phase", int'(bus0.phase), 0);
      check("t2_err", int'(bus0.err), 1);
      clear_err();
      check("t2_clr", int'(bus0.err), 0);
      pulse(1, 3, 1, PW);
      tick(10);
      check("t2_phase_b", int'(bus0.phase), 1);
      pulse(0, 3, 1, PW);
      tick(10);
      check("t2_cnt", int'(bus0.pair_cnt), 2);

      // simultaneous A and B in WAIT_A
      fork
         pulse(1, 3, 1, PW);
         pulse(0, 3, 0, 0);
      join
      tick(10);
      check("t3_phase", int'(bus0.phase), 1);
      check("t3_err", int'(bus0.err), 1);
      clear_err();
      pulse(0, 3, 1, PW);
      tick(10);
      check("t3_phase_a", int'(bus0.phase), 0);
      check("t3_err_clr", int'(bus0.err), 0);
      check("t3_cnt", int'(bus0.pair_cnt), 3);

      // B arrives during OUT_A: overrun
      fork
         pulse(1, 3, 1, PW);
         begin
            tick(4);
            pulse(0, 3, 0, 0);
         end
      join
      tick(10);
      check("t4_phase", int'(bus0.phase), 1);
      check("t4_err", int'(bus0.err), 1);
      check("t4_busy", int'(bus0.busy), 0);
      clear_err();
      pulse(0, 3, 1, PW);
      tick(10);
      check("t4_cnt", int'(bus0.pair_cnt), 4);
      check("t4_phase_a", int'(bus0.phase), 0);

      // reset in the middle of OUT_A truncates the pulse
      pulse(1, 3, 1, 2);
      tick(1);
      rst = 1'b1;
      tick(1);
      check("t6_rst_x", int'(bus0.x_out), 0);
      check("t6_rst_phase", int'(bus0.phase), 0);
      check("t6_rst_busy", int'(bus0.busy), 0);
      check("t6_rst_cnt", int'(bus0.pair_cnt), 0);
      rst = 1'b0;
      tick(4);

      // A level held across reset release gives no edge
      rst = 1'b1;
      bus0.y_in[1] = 1'b1; bus1.y_in[1] = 1'b1;
      tick(4);
      rst = 1'b0;
      tick(10);
      bus0.y_in[1] = 1'b0; bus1.y_in[1] = 1'b0;
      tick(4);
      check("t6_hold_phase", int'(bus0.phase), 0);
      check("t6_hold_err", int'(bus0.err), 0);

      // back-to-back pairs, narrow counter wraps
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(2);
      for (int i = 1; i <= 5; i++) begin
         fork
            pulse(1, 3, 1, PW);
            begin
               tick(5);
               pulse(0, 3, 1, PW);
            end
         join
         tick(6);
         check("t5_cnt8", int'(bus0.pair_cnt), i);
         check("t5_cnt2", int'(bus1.pair_cnt), i % 4);
      end
      check("t5_err", int'(bus1.err), 0);

      tick(20);
      check("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alt_merge.md
ALT_MERGE -- requirements
Module: alt_merge

Interface
REQ-001 The block SHALL have the parameter SYNC_STAGES, default 2, giving the synchronizer depth per input channel (legal 2..3).
REQ-002 The block SHALL have the parameter PULSE_W, default 4, giving the x_out high time in clk cycles (legal 1..15).
REQ-003 The block SHALL have the parameter CNT_W, default 8, giving the pair_cnt width.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 y_in  input  2  pulse channels, asynchronous to clk; y_in[1] = channel A, y_in[0] = channel B.
REQ-007 clr_err  input  1  synchronous clear of err.
REQ-008 x_out  output  1  merged pulse stream; one pulse PULSE_W cycles wide per accepted channel edge.
REQ-009 phase  output  1  channel expected next: 0 = A, 1 = B.
REQ-010 busy  output  1  high while x_out is being driven high.
REQ-011 err  output  1  sticky order/overrun error flag.
REQ-012 pair_cnt  output  CNT_W  count of completed A-then-B pairs.

Function
REQ-013 Each y_in bit SHALL pass through its own SYNC_STAGES-deep flip-flop chain followed by a one-flop previous-value register; a rising edge = last sync stage 1 AND previous-value 0.
REQ-014 The FSM SHALL have four states: WAIT_A, OUT_A, WAIT_B, OUT_B.
REQ-015 WAIT_A, edge on A only: SHALL go to OUT_A, set x_out=1, load the pulse timer with PULSE_W.
REQ-016 WAIT_A, edge on B only: SHALL stay in WAIT_A, discard the edge, set err.
REQ-017 WAIT_A, edges on A and B in the same cycle: SHALL accept A as in REQ-015, discard B, set err.
REQ-018 WAIT_B SHALL behave symmetrically to WAIT_A with A and B swapped: B edge to OUT_B, A edge is an error, simultaneous edges accept B and flag err.
REQ-019 OUT_A/OUT_B: x_out SHALL stay high for exactly PULSE_W cycles, then go low; state SHALL move to WAIT_B or WAIT_A respectively on that same edge.
REQ-020 Any channel edge detected in OUT_A/OUT_B SHALL be discarded and SHALL set err (overrun).
REQ-021 Latency: y_in rising before clk edge k, stable afterwards, in the correct WAIT state -> x_out SHALL be high from edge k+SYNC_STAGES.
REQ-022 pair_cnt SHALL increment by 1 on the edge where OUT_B ends, wrapping from 2^CNT_W-1 to 0 without error.
REQ-023 phase SHALL be 0 in WAIT_A/OUT_A and 1 in WAIT_B/OUT_B; busy SHALL be 1 exactly in OUT_A/OUT_B.
REQ-024 err SHALL be cleared by clr_err, except when a new error condition occurs in the same cycle; then err SHALL remain 1 (set wins).
REQ-025 x_out, phase, busy, err and pair_cnt SHALL all be registered outputs.
REQ-026 A back-to-back pulse SHALL be accepted in the first cycle after OUT ends (WAIT state), with no dead cycle beyond that.

Reset
REQ-027 While rst=1: state SHALL be WAIT_A; x_out, phase, busy and err SHALL be 0; pair_cnt SHALL be 0; the pulse timer SHALL be 0.
REQ-028 The synchronizer chains and previous-value registers SHALL keep sampling y_in during rst, so a level held high across reset release produces no edge.
REQ-029 rst asserted mid-pulse SHALL force x_out low on the next edge, discarding the partial pulse and the pair in progress.

Verification
REQ-030 Default parameters, reset, then A pulse, then B pulse (each 3 clk wide, 20 cycles apart) -> two x_out pulses of 4 cycles, each starting 2 cycles after its input rise; phase 0->1->0; pair_cnt=1; err=0.
REQ-031 After reset, B pulse first -> no x_out, phase=0, err=1; then clr_err for 1 cycle -> err=0; then A pulse -> x_out pulse, phase=1.
REQ-032 A and B rise in the same cycle while in WAIT_A -> one x_out pulse, phase=1, err=1; next B pulse is accepted normally.
REQ-033 A pulse, then B rising 2 cycles after x_out rises (during OUT_A) -> only one x_out pulse, err=1, state WAIT_B; a later B pulse completes the pair.
REQ-034 CNT_W=2, 5 correct A/B pairs -> pair_cnt sequence 1,2,3,0,1; err=0.
REQ-035 y_in[1] held high across rst deassertion -> no x_out pulse; rst pulsed during OUT_A -> x_out low on the next edge, phase=0, pair_cnt=0.
